// File: rtl/multitau_pkg.sv
// Shared constants and saturating add for the multi-tau lag bank.
package multitau_pkg;

  localparam int unsigned DW   = 8;
  localparam int unsigned LAGS = 32;
  localparam int unsigned PW   = 16;
  localparam int unsigned MINP = 34;
  localparam int unsigned LW   = $clog2(LAGS);
  localparam int unsigned IW   = LW + 1;

  typedef struct packed {
    logic          sat;
    logic [DW-1:0] sum;
  } sat_sum_t;

  // Unsigned add computed DW+1 wide, clamped to all-ones on carry-out.
  function automatic sat_sum_t sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    sat_sum_t    r;
    s     = (DW+1)'(a) + (DW+1)'(b);
    r.sat = s[DW];
    r.sum = s[DW] ? {DW{1'b1}} : s[DW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/multitau_sample_feeder_lag_history.sv
// LAGS x DW sample history: shift-in push, sync clear, registered indexed read.
module lag_history
  import multitau_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  input  logic [LW-1:0] rd_idx,
  output logic [DW-1:0] rd_data
);

  logic [LAGS-1:0][DW-1:0] hist_q, hist_d;
  logic [DW-1:0]           rd_q, rd_d;

  // Next history contents and read register; clear has priority over push.
  always_comb begin
    hist_d = hist_q;
    rd_d   = rd_q;
    if (clr) begin
      hist_d = '0;
    end else if (push) begin
      hist_d = {hist_q[LAGS-2:0], din};
    end
    if (rd_en) begin
      rd_d = hist_q[rd_idx];
    end
  end

  // History and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      rd_q   <= '0;
    end else begin
      hist_q <= hist_d;
      rd_q   <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/multitau_sample_feeder.sv
// Photon window counter, lag sweep sequencer and 2:1 pair summer for one tau level.
module multitau_sample_feeder
  import multitau_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [PW-1:0] period,
  input  logic          ph_in,
  input  logic          hist_clr,
  output logic          sin,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          busy,
  output logic          ds_valid,
  output logic [DW-1:0] ds_data,
  output logic          sat_flag
);

  logic [PW-1:0] wcnt_q, wcnt_d, per_q, per_d, eff_c;
  logic [DW-1:0] cnt_q, cnt_d, a_q, a_d, prev_q, prev_d, dsd_q, dsd_d;
  logic          sin_q, sin_d, pair_q, pair_d, dsv_q, dsv_d, sat_q, sat_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          term_c, push_c, rd_en_c;
  logic [LW-1:0] rd_idx_c;
  sat_sum_t      inc_c, pair_c;

  // Window length is latched on the first cycle of each window, clamped to MINP.
  always_comb begin
    if (wcnt_q == '0) begin
      eff_c = (period < PW'(MINP)) ? PW'(MINP) : period;
    end else begin
      eff_c = per_q;
    end
    term_c = en && (wcnt_q == eff_c - PW'(1));
    inc_c  = sat_add(cnt_q, DW'(ph_in));
    pair_c = sat_add(prev_q, inc_c.sum);
  end

  // Window counting, sample close, pair summing and sticky saturation flag.
  always_comb begin
    wcnt_d = wcnt_q;
    per_d  = per_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    sin_d  = 1'b0;
    pair_d = pair_q;
    prev_d = prev_q;
    dsv_d  = 1'b0;
    dsd_d  = dsd_q;
    sat_d  = sat_q;
    push_c = 1'b0;
    if (hist_clr) begin
      wcnt_d = '0;
      cnt_d  = '0;
      pair_d = 1'b0;
      sat_d  = 1'b0;
    end else if (!en) begin
      wcnt_d = '0;
      cnt_d  = '0;
    end else begin
      per_d = eff_c;
      if (inc_c.sat) sat_d = 1'b1;
      if (term_c) begin
        wcnt_d = '0;
        cnt_d  = '0;
        a_d    = inc_c.sum;
        sin_d  = 1'b1;
        push_c = 1'b1;
        pair_d = !pair_q;
        if (pair_q) begin
          dsv_d = 1'b1;
          dsd_d = pair_c.sum;
          if (pair_c.sat) sat_d = 1'b1;
        end else begin
          prev_d = inc_c.sum;
        end
      end else begin
        wcnt_d = wcnt_q + PW'(1);
        cnt_d  = inc_c.sum;
      end
    end
  end

  // Lag sweep: read index 0 on the edge after sin, then step through LAGS-1.
  always_comb begin
    busy_d   = busy_q;
    idx_d    = idx_q;
    rd_en_c  = 1'b0;
    rd_idx_c = idx_q[LW-1:0];
    if (sin_q) begin
      busy_d   = 1'b1;
      idx_d    = IW'(1);
      rd_en_c  = 1'b1;
      rd_idx_c = '0;
    end else if (busy_q) begin
      if (idx_q == IW'(LAGS)) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        rd_en_c = 1'b1;
        idx_d   = idx_q + IW'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      per_q  <= '0;
      cnt_q  <= '0;
      a_q    <= '0;
      sin_q  <= 1'b0;
      pair_q <= 1'b0;
      prev_q <= '0;
      dsv_q  <= 1'b0;
      dsd_q  <= '0;
      sat_q  <= 1'b0;
      busy_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      sin_q  <= sin_d;
      pair_q <= pair_d;
      prev_q <= prev_d;
      dsv_q  <= dsv_d;
      dsd_q  <= dsd_d;
      sat_q  <= sat_d;
      busy_q <= busy_d;
      idx_q  <= idx_d;
    end
  end

  lag_history u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (hist_clr),
    .push    (push_c),
    .din     (inc_c.sum),
    .rd_en   (rd_en_c),
    .rd_idx  (rd_idx_c),
    .rd_data (B)
  );

  assign sin      = sin_q;
  assign A        = a_q;
  assign busy     = busy_q;
  assign ds_valid = dsv_q;
  assign ds_data  = dsd_q;
  assign sat_flag = sat_q;

endmodule
